// File: rtl/nmos_pmos_alu8_pkg.sv
// Shared types for the nmos_pmos_alu8 datapath.
// Function encodings, widths and inter-stage bundles.
package nmos_pmos_alu8_pkg;

    localparam int DATA_W  = 8;
    localparam int RADDR_W = 4;
    localparam int MADDR_W = 8;
    localparam int FUNC_W  = 3;

    typedef enum logic [FUNC_W-1:0] {
        F_ADD   = 3'b000,
        F_SUB   = 3'b001,
        F_AND   = 3'b010,
        F_OR    = 3'b011,
        F_XOR   = 3'b100,
        F_NOT_A = 3'b101,
        F_NOT_B = 3'b110,
        F_INC_A = 3'b111
    } func_e;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [RADDR_W-1:0] rd;
        func_e              func;
        logic               write;
        logic [MADDR_W-1:0] maddr;
    } rd_ex_t;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  z;
        logic               flag;
        logic [RADDR_W-1:0] rd;
        logic               write;
        logic [MADDR_W-1:0] maddr;
    } ex_wb_t;

    typedef struct packed {
        logic               valid;
        logic               write;
        logic [MADDR_W-1:0] maddr;
        logic [DATA_W-1:0]  z;
    } wb_mem_t;

endpackage

// File: rtl/nmos_pmos_alu8_if.sv
// Issue/result bus between the issue controller and the ALU core.
// The controller is the master, the ALU core the slave.
import nmos_pmos_alu8_pkg::*;

interface nmos_pmos_alu8_if;
    logic               in_valid;
    logic [RADDR_W-1:0] addr1;
    logic [RADDR_W-1:0] addr2;
    logic [RADDR_W-1:0] rd;
    logic [FUNC_W-1:0]  func;
    logic               write;
    logic [MADDR_W-1:0] memaddr;
    logic [MADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0]  mem_rd_data;
    logic [DATA_W-1:0]  zout;
    logic               carry_borrow;
    logic               out_valid;

    modport master (
        output in_valid, addr1, addr2, rd, func, write, memaddr,
        output mem_rd_addr,
        input  mem_rd_data, zout, carry_borrow, out_valid
    );

    modport slave (
        input  in_valid, addr1, addr2, rd, func, write, memaddr,
        input  mem_rd_addr,
        output mem_rd_data, zout, carry_borrow, out_valid
    );
endinterface

// File: rtl/nmos_pmos_alu8_addsub8.sv
// 8-bit ripple adder with optional B inversion and carry-in.
// Shared by ADD, SUB (inverted B, cin=1) and INC_A (B=01).
import nmos_pmos_alu8_pkg::*;

module nmos_pmos_addsub8 (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              inv_b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);
    logic [DATA_W-1:0] bx;
    logic [DATA_W:0]   c;

    assign bx   = b ^ {DATA_W{inv_b}};
    assign c[0] = cin;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign sum[i]  = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign cout = c[DATA_W];
endmodule

// File: rtl/nmos_pmos_alu8.sv
// 4-stage pipelined 8-bit ALU with 16x8 register bank
// and 256x8 result memory.
import nmos_pmos_alu8_pkg::*;

module nmos_pmos_alu8 (
    input logic              clk,
    input logic              rst_n,
    nmos_pmos_alu8_if.slave  bus
);
    rd_ex_t  ex;
    ex_wb_t  wb;
    wb_mem_t ms;

    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] mem  [256];

    logic [DATA_W-1:0] zout_q;
    logic              cb_q;
    logic              ov_q;

    logic [DATA_W-1:0] add_b;
    logic              inv_b;
    logic              cin;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic [DATA_W-1:0] alu_z;
    logic              alu_f;

    always_comb begin
        add_b = ex.b;
        inv_b = 1'b0;
        cin   = 1'b0;
        unique case (ex.func)
            F_SUB: begin
                inv_b = 1'b1;
                cin   = 1'b1;
            end
            F_INC_A: add_b = 8'h01;
            default: ;
        endcase
    end

    nmos_pmos_addsub8 u_addsub (
        .a     (ex.a),
        .b     (add_b),
        .inv_b (inv_b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    always_comb begin
        alu_z = '0;
        alu_f = 1'b0;
        unique case (ex.func)
            F_ADD, F_SUB, F_INC_A: begin
                alu_z = sum;
                alu_f = cout;
            end
            F_AND:   alu_z = ex.a & ex.b;
            F_OR:    alu_z = ex.a | ex.b;
            F_XOR:   alu_z = ex.a ^ ex.b;
            F_NOT_A: alu_z = ~ex.a;
            F_NOT_B: alu_z = ~ex.b;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex     <= '0;
            wb     <= '0;
            ms     <= '0;
            zout_q <= '0;
            cb_q   <= 1'b0;
            ov_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // Operand reads see the bank before this edge's write-back.
            ex.valid <= bus.in_valid;
            ex.a     <= regs[bus.addr1];
            ex.b     <= regs[bus.addr2];
            ex.rd    <= bus.rd;
            ex.func  <= func_e'(bus.func);
            ex.write <= bus.write;
            ex.maddr <= bus.memaddr;

            wb.valid <= ex.valid;
            wb.z     <= alu_z;
            wb.flag  <= alu_f;
            wb.rd    <= ex.rd;
            wb.write <= ex.write;
            wb.maddr <= ex.maddr;

            ms.valid <= wb.valid;
            ms.write <= wb.write;
            ms.maddr <= wb.maddr;
            ms.z     <= wb.z;

            ov_q <= wb.valid;
            if (wb.valid) begin
                regs[wb.rd] <= wb.z;
                zout_q      <= wb.z;
                cb_q        <= wb.flag;
            end
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ms.valid && ms.write) begin
            mem[ms.maddr] <= ms.z;
        end
    end

    assign bus.mem_rd_data  = mem[bus.mem_rd_addr];
    assign bus.zout         = zout_q;
    assign bus.carry_borrow = cb_q;
    assign bus.out_valid    = ov_q;
endmodule

// File: tb/tb_nmos_pmos_alu8.sv
// Directed-vector bench for nmos_pmos_alu8.
// Expected values are hand-computed per vector.
module tb_nmos_pmos_alu8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    nmos_pmos_alu8_if bus ();

    nmos_pmos_alu8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] r, input logic [2:0] f,
                         input logic w, input logic [7:0] ma);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.addr1    = a1;
        bus.addr2    = a2;
        bus.rd       = r;
        bus.func     = f;
        bus.write    = w;
        bus.memaddr  = ma;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.write    = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] a1, input logic [3:0] a2,
                          input logic [3:0] r, input logic [2:0] f,
                          input logic w, input logic [7:0] ma,
                          output logic [7:0] z, output logic cb,
                          output logic ov_early, output logic ov);
        issue(a1, a2, r, f, w, ma);
        @(posedge clk);
        #1;
        ov_early = bus.out_valid;
        @(posedge clk);
        #1;
        z  = bus.zout;
        cb = bus.carry_borrow;
        ov = bus.out_valid;
    endtask

    task automatic test_reset;
        logic [7:0] z;
        logic cb, ove, ov;
        run_op(4'd0, 4'd0, 4'd5, 3'b111, 1'b0, 8'h00, z, cb, ove, ov);
        checks++;
        if (z !== 8'h01 || ov !== 1'b1)
            $display("FAIL pre_reset_inc: got z=%h ov=%b want 01/1", z, ov);
        else passed++;
        issue(4'd0, 4'd0, 4'd6, 3'b101, 1'b1, 8'h3C);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.zout !== 8'h00 || bus.carry_borrow !== 1'b0 ||
            bus.out_valid !== 1'b0)
            $display("FAIL async_reset: got z=%h cb=%b ov=%b want 00/0/0",
                     bus.zout, bus.carry_borrow, bus.out_valid);
        else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd5, 4'd6, 4'd7, 3'b011, 1'b0, 8'h00, z, cb, ove, ov);
        checks++;
        if (z !== 8'h00 || cb !== 1'b0 || ov !== 1'b1)
            $display("FAIL regs_after_reset: got z=%h cb=%b ov=%b want 00/0/1",
                     z, cb, ov);
        else passed++;
    endtask

    task automatic test_basic;
        logic [7:0] z;
        logic cb, ove, ov;
        run_op(4'd0, 4'd0, 4'd1, 3'b111, 1'b0, 8'h00, z, cb, ove, ov);
        checks++;
        if (z !== 8'h01 || cb !== 1'b0 || ove !== 1'b0 || ov !== 1'b1)
            $display("FAIL inc_r0: got z=%h cb=%b ov_e1=%b ov_e2=%b want 01/0/0/1",
                     z, cb, ove, ov);
        else passed++;
        run_op(4'd0, 4'd0, 4'd2, 3'b101, 1'b0, 8'h00, z, cb, ove, ov);
        checks++;
        if (z !== 8'hFF || cb !== 1'b0 || ov !== 1'b1)
            $display("FAIL not_a_r0: got z=%h cb=%b want FF/0", z, cb);
        else passed++;
    endtask

    task automatic test_wrap;
        logic [7:0] z;
        logic cb, ove, ov;
        logic [2:0]  fv [4] = '{3'b111, 3'b000, 3'b001, 3'b001};
        logic [3:0]  av [4] = '{4'd2, 4'd2, 4'd1, 4'd2};
        logic [3:0]  bv [4] = '{4'd0, 4'd1, 4'd2, 4'd1};
        logic [7:0]  zv [4] = '{8'h00, 8'h00, 8'h02, 8'hFE};
        logic        cv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], 4'(8 + i), fv[i], 1'b0, 8'h00,
                   z, cb, ove, ov);
            checks++;
            if (z !== zv[i] || cb !== cv[i] || ov !== 1'b1)
                $display("FAIL wrap_%0d: got z=%h cb=%b want %h/%b",
                         i, z, cb, zv[i], cv[i]);
            else passed++;
        end
    endtask

    task automatic test_logic;
        logic [7:0] z;
        logic cb, ove, ov;
        logic [2:0]  fv [4] = '{3'b010, 3'b011, 3'b100, 3'b110};
        logic [3:0]  av [4] = '{4'd2, 4'd1, 4'd2, 4'd0};
        logic [3:0]  bv [4] = '{4'd1, 4'd0, 4'd1, 4'd1};
        logic [7:0]  zv [4] = '{8'h01, 8'h01, 8'hFE, 8'hFE};
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], 4'(12 + i), fv[i], 1'b0, 8'h00,
                   z, cb, ove, ov);
            checks++;
            if (z !== zv[i] || cb !== 1'b0 || ov !== 1'b1)
                $display("FAIL logic_%0d: got z=%h cb=%b want %h/0",
                         i, z, cb, zv[i]);
            else passed++;
        end
    endtask

    task automatic test_memory;
        logic [7:0] z;
        logic cb, ove, ov;
        bus.mem_rd_addr = 8'hA5;
        run_op(4'd1, 4'd1, 4'd10, 3'b000, 1'b1, 8'hA5, z, cb, ove, ov);
        checks++;
        if (z !== 8'h02)
            $display("FAIL mem_add_z: got %h want 02", z);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (bus.mem_rd_data !== 8'h02)
            $display("FAIL mem_store_a5: got %h want 02", bus.mem_rd_data);
        else passed++;
        run_op(4'd2, 4'd0, 4'd10, 3'b000, 1'b1, 8'hA5, z, cb, ove, ov);
        checks++;
        if (bus.mem_rd_data !== 8'h02)
            $display("FAIL mem_old_before_edge: got %h want 02",
                     bus.mem_rd_data);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (bus.mem_rd_data !== 8'hFF)
            $display("FAIL mem_overwrite: got %h want FF", bus.mem_rd_data);
        else passed++;
        run_op(4'd1, 4'd1, 4'd10, 3'b000, 1'b0, 8'hA5, z, cb, ove, ov);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (z !== 8'h02 || bus.mem_rd_data !== 8'hFF)
            $display("FAIL mem_no_write: got z=%h mem=%h want 02/FF",
                     z, bus.mem_rd_data);
        else passed++;
    endtask

    task automatic test_hazard;
        logic [7:0] z;
        logic cb, ove, ov;
        issue(4'd1, 4'd0, 4'd4, 3'b111, 1'b0, 8'h00);
        issue(4'd4, 4'd0, 4'd5, 3'b000, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (bus.zout !== 8'h02 || bus.out_valid !== 1'b1)
            $display("FAIL hazard_producer: got %h want 02", bus.zout);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (bus.zout !== 8'h00 || bus.out_valid !== 1'b1)
            $display("FAIL hazard_stale: got %h want 00", bus.zout);
        else passed++;
        run_op(4'd4, 4'd0, 4'd5, 3'b000, 1'b0, 8'h00, z, cb, ove, ov);
        checks++;
        if (z !== 8'h02 || cb !== 1'b0)
            $display("FAIL hazard_fresh: got %h want 02", z);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] z;
        logic cb, ove, ov;
        issue(4'd1, 4'd0, 4'd6, 3'b111, 1'b0, 8'h00);
        issue(4'd0, 4'd0, 4'd6, 3'b101, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        run_op(4'd6, 4'd0, 4'd7, 3'b011, 1'b0, 8'h00, z, cb, ove, ov);
        checks++;
        if (z !== 8'hFF)
            $display("FAIL same_rd_last_wins: got %h want FF", z);
        else passed++;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.addr1       = '0;
        bus.addr2       = '0;
        bus.rd          = '0;
        bus.func        = '0;
        bus.write       = 1'b0;
        bus.memaddr     = '0;
        bus.mem_rd_addr = '0;
        #1;
        checks++;
        if (bus.zout !== 8'h00 || bus.carry_borrow !== 1'b0 ||
            bus.out_valid !== 1'b0)
            $display("FAIL reset_state: got z=%h cb=%b ov=%b want 00/0/0",
                     bus.zout, bus.carry_borrow, bus.out_valid);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_logic();
        test_memory();
        test_hazard();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
